// File: rtl/bcd_pkg.sv
// Shared constants and FSM encoding for the sequential packed-BCD subtractor.
package bcd_pkg;

    localparam int         DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/bcd_digit_sub.sv
// One decimal digit of a - b - bin; combinational, 0 cycles, no handshake.
// A negative raw difference is folded back into 0..9 by adding ten and raising bout.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               bin,
    output logic [DIGIT_W-1:0] d,
    output logic               bout
);

    logic signed [4:0] t;

    always_comb begin
        t    = $signed({1'b0, a}) - $signed({1'b0, b}) - $signed({4'b0000, bin});
        bout = t[4];
        d    = t[3:0] + (bout ? 4'd10 : 4'd0);
    end

endmodule

// File: rtl/bcd_subtractor_seq.sv
// Packed-BCD A-B, one digit per clock LSD first; DIGITS cycles (2*DIGITS with BCD_SUB_MAGNITUDE_EN and A<B).
// Operands taken only in IDLE; result held in DONE until out_ready.
module bcd_subtractor_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DIGITS*DIGIT_W-1:0]   a,
    input  logic [DIGITS*DIGIT_W-1:0]   b,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [DIGITS*DIGIT_W-1:0]   diff,
    output logic                        borrow,
    output logic                        err,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int W     = DIGITS * DIGIT_W;
    localparam int IDX_W = $clog2(DIGITS + 1);

    state_t             state;
    state_t             state_nxt;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       diff_q;
    logic [IDX_W-1:0]   idx;
    logic               bin_q;
    logic               borrow_q;
    logic               err_q;

    logic               accept;
    logic               step_en;
    logic               last_digit;
    logic               in_bad;
    logic [DIGIT_W-1:0] cur_a;
    logic [DIGIT_W-1:0] cur_b;
    logic [DIGIT_W-1:0] cur_d;
    logic [DIGIT_W-1:0] op_a;
    logic [DIGIT_W-1:0] op_b;
    logic [DIGIT_W-1:0] d_step;
    logic               bout_step;

    assign accept     = in_valid && (state == IDLE);
    assign last_digit = (idx == IDX_W'(DIGITS - 1));

    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[i*DIGIT_W +: DIGIT_W] > BCD_MAX || b[i*DIGIT_W +: DIGIT_W] > BCD_MAX)
                in_bad = 1'b1;
        end
    end

    always_comb begin
        cur_a = '0;
        cur_b = '0;
        cur_d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_a = a_q[i*DIGIT_W +: DIGIT_W];
                cur_b = b_q[i*DIGIT_W +: DIGIT_W];
                cur_d = diff_q[i*DIGIT_W +: DIGIT_W];
            end
        end
    end

    // The magnitude pass reuses the digit subtractor as 0 - diff, i.e. ten's complement.
    always_comb begin
        op_a    = cur_a;
        op_b    = cur_b;
        step_en = (state == SUB);
`ifdef BCD_SUB_MAGNITUDE_EN
        if (state == NEG) begin
            op_a    = '0;
            op_b    = cur_d;
            step_en = 1'b1;
        end
`endif
    end

    bcd_digit_sub u_digit (
        .a    (op_a),
        .b    (op_b),
        .bin  (bin_q),
        .d    (d_step),
        .bout (bout_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = SUB;
            SUB: begin
                if (last_digit) begin
`ifdef BCD_SUB_MAGNITUDE_EN
                    state_nxt = (bout_step && !err_q) ? NEG : DONE;
`else
                    state_nxt = DONE;
`endif
                end
            end
`ifdef BCD_SUB_MAGNITUDE_EN
            NEG:  if (last_digit) state_nxt = DONE;
`endif
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        diff      = err_q ? '0 : diff_q;
        borrow    = borrow_q && !err_q;
        err       = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            idx      <= '0;
            bin_q    <= 1'b0;
            borrow_q <= 1'b0;
            err_q    <= 1'b0;
        end else if (accept) begin
            a_q      <= a;
            b_q      <= b;
            diff_q   <= '0;
            idx      <= '0;
            bin_q    <= 1'b0;
            borrow_q <= 1'b0;
            err_q    <= in_bad;
        end else if (step_en) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (idx == IDX_W'(i))
                    diff_q[i*DIGIT_W +: DIGIT_W] <= d_step;
            end
            if (last_digit) begin
                idx   <= '0;
                bin_q <= 1'b0;
                if (state == SUB)
                    borrow_q <= bout_step;
            end else begin
                idx   <= idx + IDX_W'(1);
                bin_q <= bout_step;
            end
        end
    end

endmodule
